// File: rtl/spike_rate_decoder_if.sv
// Spike-train input and rate/ISI result handshake bundle for spike_rate_decoder.
// The master side drives spikes and consumes results; the decoder is the slave.
interface spike_rate_decoder_if #(
  parameter int CNT_W = 8,
  parameter int ISI_W = 8
);
  logic             enable;
  logic             spike_in;
  logic [CNT_W-1:0] rate_out;
  logic [ISI_W-1:0] isi_out;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  modport master (
    output enable, spike_in, out_ready,
    input  rate_out, isi_out, out_valid, overrun
  );

  modport slave (
    input  enable, spike_in, out_ready,
    output rate_out, isi_out, out_valid, overrun
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Decodes a one-bit spike train into a per-window saturating spike count and the
// latest inter-spike interval, offered through a valid/ready holding register.
module spike_rate_decoder #(
  parameter int WINDOW = 256,
  parameter int CNT_W  = 8,
  parameter int ISI_W  = 8
) (
  input logic                 clk,
  input logic                 reset,
  spike_rate_decoder_if.slave bus
);
  localparam int WIN_W = $clog2(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [ISI_W-1:0] ISI_MAX  = '1;
  localparam logic [ISI_W-1:0] ISI_ONE  = ISI_W'(1);

  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [ISI_W-1:0] isi_run_q, isi_run_d;
  logic             seen_q, seen_d;
  logic [ISI_W-1:0] isi_last_q, isi_last_d;
  logic [CNT_W-1:0] rate_q, rate_d;
  logic [ISI_W-1:0] isi_q, isi_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             spike;
  logic             win_end;
  logic [CNT_W-1:0] acc_inc;

  always_comb begin
    spike   = bus.enable & bus.spike_in;
    win_end = bus.enable && (win_cnt_q == WIN_LAST);
    acc_inc = (spike && (acc_q != CNT_MAX)) ? acc_q + CNT_ONE : acc_q;

    win_cnt_d  = win_cnt_q;
    acc_d      = acc_q;
    isi_run_d  = isi_run_q;
    seen_d     = seen_q;
    isi_last_d = isi_last_q;
    rate_d     = rate_q;
    isi_d      = isi_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;

    if (bus.enable) begin
      win_cnt_d = win_end ? '0 : win_cnt_q + WIN_ONE;
      acc_d     = win_end ? '0 : acc_inc;
      if (spike) begin
        // The first spike only arms the tracker; an interval needs two spikes.
        if (seen_q) begin
          isi_last_d = (isi_run_q == ISI_MAX) ? ISI_MAX : isi_run_q + ISI_ONE;
        end
        isi_run_d = '0;
        seen_d    = 1'b1;
      end else if (isi_run_q != ISI_MAX) begin
        isi_run_d = isi_run_q + ISI_ONE;
      end
    end

    // A fresh result wins over a transfer; overwriting an unread one is flagged.
    if (win_end) begin
      rate_d  = acc_inc;
      isi_d   = isi_last_d;
      valid_d = 1'b1;
      if (valid_q && !bus.out_ready) begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt_q  <= '0;
      acc_q      <= '0;
      isi_run_q  <= '0;
      seen_q     <= 1'b0;
      isi_last_q <= '0;
      rate_q     <= '0;
      isi_q      <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      win_cnt_q  <= win_cnt_d;
      acc_q      <= acc_d;
      isi_run_q  <= isi_run_d;
      seen_q     <= seen_d;
      isi_last_q <= isi_last_d;
      rate_q     <= rate_d;
      isi_q      <= isi_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.rate_out  = rate_q;
  assign bus.isi_out   = isi_q;
  assign bus.out_valid = valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_spike_rate_decoder.sv
// Randomized bench for spike_rate_decoder against a spike-time-list reference model.
// Small counter widths make both saturation limits reachable.
module tb_spike_rate_decoder;
  localparam int WINDOW  = 12;
  localparam int CNT_W   = 3;
  localparam int ISI_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam int ISI_MAX = (1 << ISI_W) - 1;

  logic clk = 1'b0;
  logic reset;

  spike_rate_decoder_if #(.CNT_W(CNT_W), .ISI_W(ISI_W)) bus ();

  spike_rate_decoder #(.WINDOW(WINDOW), .CNT_W(CNT_W), .ISI_W(ISI_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total_checks = 0;
  int bad_checks   = 0;

  // Reference model: enabled-cycle timeline with spike positions.
  int en_count;
  int win_spikes;
  bit have_last;
  int last_idx;
  int last_isi;
  int exp_rate;
  int exp_isi;
  bit exp_valid;
  bit exp_overrun;

  task automatic check_val(input string tag, input int got, input int exp);
    total_checks++;
    if (got != exp) begin
      bad_checks++;
      $display("FAIL %s got=%0d want=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    en_count    = 0;
    win_spikes  = 0;
    have_last   = 0;
    last_idx    = 0;
    last_isi    = 0;
    exp_rate    = 0;
    exp_isi     = 0;
    exp_valid   = 0;
    exp_overrun = 0;
  endtask

  task automatic model_step(input bit en, input bit sp, input bit rdy);
    bit win_end;
    bit xfer;
    win_end = 0;
    xfer    = exp_valid && rdy;
    if (en) begin
      if (sp) begin
        win_spikes++;
        if (have_last)
          last_isi = (en_count - last_idx > ISI_MAX) ? ISI_MAX : en_count - last_idx;
        last_idx  = en_count;
        have_last = 1;
      end
      en_count++;
      win_end = (en_count % WINDOW) == 0;
    end
    if (win_end) begin
      if (exp_valid && !rdy) exp_overrun = 1;
      exp_rate   = (win_spikes > CNT_MAX) ? CNT_MAX : win_spikes;
      exp_isi    = last_isi;
      exp_valid  = 1;
      win_spikes = 0;
    end else if (xfer) begin
      exp_valid = 0;
    end
  endtask

  task automatic check_outputs(input string phase);
    check_val({phase, ".rate"},    int'(bus.rate_out),  exp_rate);
    check_val({phase, ".isi"},     int'(bus.isi_out),   exp_isi);
    check_val({phase, ".valid"},   int'(bus.out_valid), int'(exp_valid));
    check_val({phase, ".overrun"}, int'(bus.overrun),   int'(exp_overrun));
  endtask

  // Called #1 after an edge: drive, predict, take the edge, compare.
  task automatic do_cycle(input bit en, input bit sp, input bit rdy);
    bus.enable    = en;
    bus.spike_in  = sp;
    bus.out_ready = rdy;
    model_step(en, sp, rdy);
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  // Reset lands between edges; outputs must clear before any clock arrives.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs("rst_hold");
  endtask

  int sp_tab[5] = '{0, 10, 33, 50, 100};
  int en_p, sp_p, rdy_p;

  initial begin
    reset         = 1'b1;
    bus.enable    = 1'b0;
    bus.spike_in  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    reset = 1'b0;

    for (int seg = 0; seg < 30; seg++) begin
      if (seg == 10 || seg == 20) async_reset();
      if (seg == 9 || seg == 19) begin
        en_p  = 100;
        sp_p  = 50;
        rdy_p = 0;
      end else begin
        en_p  = ($urandom_range(0, 2) == 0) ? 70 : 100;
        sp_p  = sp_tab[$urandom_range(0, 4)];
        rdy_p = ($urandom_range(0, 2) == 0) ? 0 : (($urandom_range(0, 1) == 0) ? 50 : 100);
      end
      for (int c = 0; c < 40; c++) begin
        do_cycle($urandom_range(0, 99) < en_p,
                 $urandom_range(0, 99) < sp_p,
                 $urandom_range(0, 99) < rdy_p);
      end
    end

    // Drain any pending result with a frozen window.
    for (int c = 0; c < 3; c++) do_cycle(1'b0, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end
endmodule
